pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write-enable and flush controls. It resolves load-use hazards, branch/jump redirects and variable-latency data-memory accesses, and traps on a memory timeout. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush controls exchanged between the pipeline
// datapath and the pipeline_ctrl sequencer.
`timescale 1ns/1ps
interface pipeline_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             ID_uses_rt;
  logic             ID_jump;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_Write_Register;
  logic             EX_branch_taken;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic             dmem_ready;

  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_hold;
  logic             MEM_WB_bubble;
  logic             dmem_req;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;

  // Sequencer side.
  modport master (
    input  ID_rs, ID_rt, ID_uses_rt, ID_jump, EX_MemRead, EX_Write_Register,
           EX_branch_taken, MEM_MemRead, MEM_MemWrite, dmem_ready,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold,
           MEM_WB_bubble, dmem_req, mem_fault, stall_cycles
  );

  // Datapath side.
  modport slave (
    output ID_rs, ID_rt, ID_uses_rt, ID_jump, EX_MemRead, EX_Write_Register,
           EX_branch_taken, MEM_MemRead, MEM_MemWrite, dmem_ready,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold,
           MEM_WB_bubble, dmem_req, mem_fault, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirects,
// variable-latency data memory with timeout trap, and a stall-cycle counter.
`timescale 1ns/1ps
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic          sysclk,
  input logic          reset,
  pipeline_ctrl_if.master bus
);
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              fault;

  logic mem_acc;
  logic mem_stall;
  logic load_use;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_hold;
  logic mem_wb_bubble;
  logic dmem_req;

  assign mem_acc   = bus.MEM_MemRead | bus.MEM_MemWrite;
  assign mem_stall = mem_acc & ~bus.dmem_ready & (state != TRAP);
  assign load_use  = bus.EX_MemRead & (bus.EX_Write_Register != 5'd0) &
                     ((bus.EX_Write_Register == bus.ID_rs) |
                      (bus.ID_uses_rt & (bus.EX_Write_Register == bus.ID_rt)));

  // Prioritised control decode; lower-priority hazards are masked by higher ones.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_req      = mem_acc & (state != TRAP);
    if (reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
      dmem_req      = 1'b0;
    end else if (state == TRAP) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (mem_stall) begin
      // ID/EX enable follows EX_MEM_hold, so the whole back end freezes.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (bus.EX_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_flush   = 1'b1;
    end else if (bus.ID_jump) begin
      if_id_flush   = 1'b1;
    end
  end

  // State, memory wait counter, fault flag and saturating stall counter.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt < TIMEOUT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            state <= TRAP;
            fault <= 1'b1;
          end
        end
        default: begin
          state <= TRAP;
        end
      endcase
    end
  end

  assign bus.PC_write      = pc_write;
  assign bus.IF_ID_write   = if_id_write;
  assign bus.IF_ID_flush   = if_id_flush;
  assign bus.ID_EX_flush   = id_ex_flush;
  assign bus.EX_MEM_hold   = ex_mem_hold;
  assign bus.MEM_WB_bubble = mem_wb_bubble;
  assign bus.dmem_req      = dmem_req;
  assign bus.mem_fault     = fault;
  assign bus.stall_cycles  = stall_cnt;
endmodule
